// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//
// UART 8N1 serial transmitter with its own gated baud-tick generator.
// One byte is accepted per start request while idle and shifted out
// LSB-first: a start bit (0), eight data bits, then a stop bit (1).
// The tick generator only runs while a frame is in flight, so every frame
// is aligned to the cycle its start was accepted in.
//
// Ports
//   clk                   in   1  system clock, rising edge
//   rst_n                 in   1  synchronous reset, active HIGH despite the name
//   i_tx_start            in   1  start request, looked at only while idle
//   i_data                in   8  byte to send, captured when the start is accepted
//   o_rs232_txd           out  1  serial line, idles high
//   o_baudrate_tx_clk_en  out  1  high while a frame is in flight
//   o_tx_done             out  1  one-cycle pulse after the stop bit completes
//
// All outputs come straight from flops; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module uart_tx_core #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_data,
  output logic       o_rs232_txd,
  output logic       o_baudrate_tx_clk_en,
  output logic       o_tx_done
);

  // Counter wide enough for 0..CLKS_PER_BIT-1. The guard keeps the width
  // legal if someone ever instantiates with CLKS_PER_BIT of 1.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             tick;

  // Baud tick generator. The counter is parked at zero while the enable
  // is low, so the first tick of a frame lands exactly CLKS_PER_BIT cycles
  // after the start is accepted. It wraps on the tick cycle itself, which
  // makes every bit period exactly CLKS_PER_BIT clocks long.
  assign tick = en_q && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = '0;
    if (en_q) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame sequencer, next-state side. The line level, enable and done
  // pulse are all computed here one cycle ahead and registered, so a
  // state change and its line level appear together on the outputs.
  // The shift register moves right on every bit boundary so the next
  // data bit is always sitting in bit 0.
  always_comb begin
    state_d  = state_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    en_d     = en_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        en_d  = 1'b0;
        if (i_tx_start) begin
          shift_d  = i_data;
          bitIdx_d = 3'd0;
          en_d     = 1'b1;
          txd_d    = 1'b0;
          state_d  = START;
        end
      end

      START: begin
        if (tick) begin
          txd_d    = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          bitIdx_d = 3'd0;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          if (bitIdx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            txd_d    = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end

      STOP: begin
        // The done cycle is already IDLE, so a start presented alongside
        // the done pulse is accepted and the stop bit stretches by one.
        if (tick) begin
          txd_d   = 1'b1;
          en_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        txd_d   = 1'b1;
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any frame in flight: the
  // line returns high on the very next cycle and no done pulse is issued.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  assign o_rs232_txd          = txd_q;
  assign o_baudrate_tx_clk_en = en_q;
  assign o_tx_done            = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core
//
// Directed bench for uart_tx_core. A small instance (4 clocks per bit)
// exercises framing, ignored inputs, back-to-back frames and mid-frame
// reset; a second instance with default parameters checks the real bit
// period. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

  localparam int N    = 4;
  localparam int NBIG = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       txd, en, done;
  logic       bigStart;
  logic [7:0] bigData;
  logic       bigTxd, bigEn, bigDone;

  int testCount = 0;
  int failCount = 0;
  int cycle     = 0;
  int stopLen   = 0;

  int kCycle, doneCycle1, fallCycle, correct, bigDoneSeen;

  always #5 clk = ~clk;

  uart_tx_core #(.CLKS_PER_BIT(N)) dutSmall (
    .clk                 (clk),
    .rst_n               (rst),
    .i_tx_start          (start),
    .i_data              (data),
    .o_rs232_txd         (txd),
    .o_baudrate_tx_clk_en(en),
    .o_tx_done           (done)
  );

  uart_tx_core dutBig (
    .clk                 (clk),
    .rst_n               (rst),
    .i_tx_start          (bigStart),
    .i_data              (bigData),
    .o_rs232_txd         (bigTxd),
    .o_baudrate_tx_clk_en(bigEn),
    .o_tx_done           (bigDone)
  );

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to the next cycle and settle just after the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    start = s;
    data  = d;
  endtask

  task automatic checkSmall(input string tag, input logic eTxd, input logic eEn,
                            input logic eDone);
    checkOutput({tag, ".txd"},  {31'd0, txd},  {31'd0, eTxd});
    checkOutput({tag, ".en"},   {31'd0, en},   {31'd0, eEn});
    checkOutput({tag, ".done"}, {31'd0, done}, {31'd0, eDone});
  endtask

  // Entered in the cycle a start for byte b is presented; walks the
  // 10*N frame cycles checking the line level every cycle and leaves off
  // in the last stop cycle. Optionally scribbles on i_data or pulses
  // start while the frame is in the data phase.
  task automatic runFrame(input logic [7:0] b, input bit changeData,
                          input bit pokeStart, input string tag);
    for (int bitNum = 0; bitNum < 10; bitNum++) begin
      logic lvl;
      if (bitNum == 0)      lvl = 1'b0;
      else if (bitNum == 9) lvl = 1'b1;
      else                  lvl = b[bitNum-1];
      for (int c = 0; c < N; c++) begin
        nextCycle();
        if (bitNum == 0 && c == 0) start = 1'b0;
        if (changeData && bitNum == 3 && c == 0) data = 8'hFF;
        if (pokeStart && bitNum == 5 && c == 1) start = 1'b1;
        if (pokeStart && bitNum == 5 && c == 2) start = 1'b0;
        checkSmall($sformatf("%s.bit%0d.c%0d", tag, bitNum, c), lvl, 1'b1, 1'b0);
        if (bitNum == 9 && txd === 1'b1) stopLen++;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    data     = 8'h00;
    bigStart = 1'b0;
    bigData  = 8'h00;

    // Reset for three cycles.
    repeat (3) nextCycle();
    checkSmall("reset", 1'b1, 1'b0, 1'b0);
    checkOutput("reset.bigTxd", {31'd0, bigTxd}, 32'd1);
    checkOutput("reset.bigEn",  {31'd0, bigEn},  32'd0);
    rst = 1'b0;

    // Nothing happens while start stays low.
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkSmall($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // 0x55: alternating data, single done pulse at k+41.
    applyStimulus(1'b1, 8'h55);
    kCycle = cycle;
    runFrame(8'h55, 1'b0, 1'b0, "f55");
    nextCycle();
    checkSmall("f55.done", 1'b1, 1'b0, 1'b1);
    checkOutput("f55.doneAt", cycle - kCycle, 32'd41);
    nextCycle();
    checkSmall("f55.after", 1'b1, 1'b0, 1'b0);

    // 0xA3 with i_data overwritten and start pulsed mid-frame.
    applyStimulus(1'b1, 8'hA3);
    runFrame(8'hA3, 1'b1, 1'b1, "fA3");
    nextCycle();
    checkSmall("fA3.done", 1'b1, 1'b0, 1'b1);
    nextCycle();
    checkSmall("fA3.after", 1'b1, 1'b0, 1'b0);

    // 0x00 then 0xFF with the second start in the done cycle.
    applyStimulus(1'b1, 8'h00);
    stopLen = 0;
    runFrame(8'h00, 1'b0, 1'b0, "b2b0");
    nextCycle();
    checkSmall("b2b0.done", 1'b1, 1'b0, 1'b1);
    if (txd === 1'b1) stopLen++;
    checkOutput("b2b.stopLen", stopLen, 32'd5);
    doneCycle1 = cycle;
    applyStimulus(1'b1, 8'hFF);
    runFrame(8'hFF, 1'b0, 1'b0, "b2b1");
    nextCycle();
    checkSmall("b2b1.done", 1'b1, 1'b0, 1'b1);
    checkOutput("b2b.doneGap", cycle - doneCycle1, 32'd41);
    nextCycle();
    checkSmall("b2b1.after", 1'b1, 1'b0, 1'b0);

    // Reset during data bit 3 of a 0x3C frame (bit 3 is a 1).
    applyStimulus(1'b1, 8'h3C);
    nextCycle();
    start = 1'b0;
    checkSmall("abort.startBit", 1'b0, 1'b1, 1'b0);
    repeat (4 * N + 1) nextCycle();
    checkSmall("abort.bit3", 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    nextCycle();
    checkSmall("abort.reset", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      nextCycle();
      checkSmall($sformatf("abort.quiet%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // A clean 0x81 frame after the aborted one.
    applyStimulus(1'b1, 8'h81);
    runFrame(8'h81, 1'b0, 1'b0, "f81");
    nextCycle();
    checkSmall("f81.done", 1'b1, 1'b0, 1'b1);

    // Default parameters: 0x5A, each bit 434 cycles, done 4340 after the fall.
    bigData  = 8'h5A;
    bigStart = 1'b1;
    checkOutput("big.idleTxd", {31'd0, bigTxd}, 32'd1);
    nextCycle();
    bigStart    = 1'b0;
    fallCycle   = cycle;
    bigDoneSeen = 0;
    for (int bitNum = 0; bitNum < 10; bitNum++) begin
      logic lvl;
      if (bitNum == 0)      lvl = 1'b0;
      else if (bitNum == 9) lvl = 1'b1;
      else                  lvl = bigData[bitNum-1];
      correct = 0;
      for (int c = 0; c < NBIG; c++) begin
        if (bitNum > 0 || c > 0) nextCycle();
        if (bigTxd === lvl && bigEn === 1'b1) correct++;
        if (bigDone !== 1'b0) bigDoneSeen++;
      end
      checkOutput($sformatf("big.bit%0d", bitNum), correct, NBIG);
    end
    checkOutput("big.earlyDone", bigDoneSeen, 32'd0);
    nextCycle();
    checkOutput("big.done", {31'd0, bigDone}, 32'd1);
    checkOutput("big.enOff", {31'd0, bigEn}, 32'd0);
    checkOutput("big.frameLen", cycle - fallCycle, 32'd4340);
    nextCycle();
    checkOutput("big.doneOnce", {31'd0, bigDone}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
